// File: rtl/adat_encoder.sv
// ADAT lightpipe transmitter: streams 8 x 24-bit frames from a circular channel buffer as 256-slot NRZI.
// Build option ADAT_ENCODER_UNDERRUN_MUTE_EN mutes (and holds the index of) frames the producer has not written.
module adat_encoder #(
  parameter int CIRC_BUF_BITS = 3,
  parameter int CLK_DIV       = 4
) (
  input  logic                     clk_x4_i,
  input  logic                     reset_ni,
  input  logic                     enable_i,
  input  logic [3:0]               user_bits_i,
  input  logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_i,
  output logic [CIRC_BUF_BITS+7:0] ram_read_addr_o,
  input  logic                     ram_read_data_i,
  output logic [CIRC_BUF_BITS-1:0] tx_frame_idx_o,
  output logic                     frame_start_o,
  output logic                     underrun_o,
  output logic                     nrzi_o
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_USER, ST_DATA} state_t;

  state_t                   state_reg, state_next;
  logic [PW-1:0]            phase_reg;
  logic [7:0]               slot_reg, slot_next;
  logic [2:0]               pos_reg, pos_next;
  logic                     slot_end;

  logic                     nrzi_reg;
  logic                     frame_start_reg;
  logic                     underrun_reg;
  logic                     mute_reg;
  logic [3:0]               user_reg;
  logic [CIRC_BUF_BITS-1:0] frame_idx_reg, frame_idx_next;
  logic [CIRC_BUF_BITS+7:0] addr_reg;
  logic                     next_bit_reg;
  logic [2:0]               rd_ch_reg;
  logic [4:0]               rd_k_reg;

  logic                     frame_begin;
  logic                     frame_done;
  logic                     slot_bit;
  logic                     toggle;
  logic                     fetch_en;
  logic                     addr_load;
  logic                     bit_load;
  logic                     mute_cond;

  assign slot_end = (phase_reg == PH_LAST);

  // State register: phase counter free-runs so IDLE -> SYNC always lands on a phase-0 boundary.
  always_ff @(posedge clk_x4_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg <= ST_IDLE;
      phase_reg <= '0;
      slot_reg  <= '0;
      pos_reg   <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_reg + PW'(1);
      slot_reg  <= slot_next;
      pos_reg   <= pos_next;
    end
  end

  // Next-state logic: one slot decision per phase wrap.
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    pos_next   = pos_reg;
    if (slot_end) begin
      slot_next = slot_reg + 8'd1;
      case (state_reg)
        ST_IDLE: begin
          slot_next = 8'd0;
          if (enable_i) state_next = ST_SYNC;
        end
        ST_SYNC: if (slot_reg == 8'd10) state_next = ST_USER;
        ST_USER: if (slot_reg == 8'd15) begin
          state_next = ST_DATA;
          pos_next   = 3'd0;
        end
        ST_DATA: begin
          pos_next = (pos_reg == 3'd4) ? 3'd0 : pos_reg + 3'd1;
          if (slot_reg == 8'd255) state_next = enable_i ? ST_SYNC : ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output/control decode: bit value of the slot about to start, and RAM prefetch strobes.
  always_comb begin
    frame_begin = slot_end && (state_next == ST_SYNC) && (slot_next == 8'd0);
    frame_done  = slot_end && (state_reg == ST_DATA) && (slot_reg == 8'd255);
    slot_bit    = 1'b0;
    case (state_next)
      ST_SYNC: slot_bit = (slot_next == 8'd10);
      ST_USER: begin
        case (slot_next)
          8'd11:   slot_bit = user_reg[3];
          8'd12:   slot_bit = user_reg[2];
          8'd13:   slot_bit = user_reg[1];
          8'd14:   slot_bit = user_reg[0];
          default: slot_bit = 1'b1;
        endcase
      end
      ST_DATA: slot_bit = (pos_next == 3'd4) ? 1'b1 : (next_bit_reg & ~mute_reg);
      default: slot_bit = 1'b0;
    endcase
    toggle   = slot_end && (state_next != ST_IDLE) && slot_bit;
    fetch_en = !mute_reg &&
               (((state_reg == ST_USER) && (slot_reg == 8'd15)) ||
                ((state_reg == ST_DATA) && (pos_reg != 3'd3) && (slot_reg != 8'd255)));
    addr_load = fetch_en && (phase_reg == PW'(0));
    bit_load  = fetch_en && (phase_reg == PW'(2));
    frame_idx_next = (frame_done && !mute_reg) ? frame_idx_reg + CIRC_BUF_BITS'(1) : frame_idx_reg;
  end

`ifdef ADAT_ENCODER_UNDERRUN_MUTE_EN
  logic [CIRC_BUF_BITS-1:0] good_next;
  assign good_next = last_good_frame_idx_i + CIRC_BUF_BITS'(1);
  assign mute_cond = (frame_idx_next == good_next);
`else
  logic unused_last_good;
  assign unused_last_good = ^last_good_frame_idx_i;
  assign mute_cond        = 1'b0;
`endif

  always_ff @(posedge clk_x4_i or negedge reset_ni) begin
    if (!reset_ni) begin
      nrzi_reg        <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
      mute_reg        <= 1'b0;
      user_reg        <= '0;
      frame_idx_reg   <= '0;
      addr_reg        <= '0;
      next_bit_reg    <= 1'b0;
      rd_ch_reg       <= '0;
      rd_k_reg        <= '0;
    end else begin
      nrzi_reg        <= nrzi_reg ^ toggle;
      frame_start_reg <= frame_begin;
      underrun_reg    <= frame_begin && mute_cond;
      frame_idx_reg   <= frame_idx_next;
      if (frame_begin) begin
        user_reg  <= user_bits_i;
        mute_reg  <= mute_cond;
        rd_ch_reg <= '0;
        rd_k_reg  <= '0;
      end
      if (addr_load) addr_reg <= {frame_idx_reg, rd_ch_reg, rd_k_reg};
      // Only sample bits 0..23 are ever addressed; wrap to the next channel after the LSB.
      if (bit_load) begin
        next_bit_reg <= ram_read_data_i;
        if (rd_k_reg == 5'd23) begin
          rd_k_reg  <= '0;
          rd_ch_reg <= rd_ch_reg + 3'd1;
        end else begin
          rd_k_reg <= rd_k_reg + 5'd1;
        end
      end
    end
  end

  assign nrzi_o          = nrzi_reg;
  assign frame_start_o   = frame_start_reg;
  assign underrun_o      = underrun_reg;
  assign tx_frame_idx_o  = frame_idx_reg;
  assign ram_read_addr_o = addr_reg;

endmodule
